light_sequencer: RTL and testbench

LIGHT_SEQUENCER -- requirements
Module: light_sequencer

---
 rtl/light_sequencer_pkg.sv | 21 ++
 rtl/light_sequencer_if.sv | 35 +++
 rtl/light_sequencer_dur_reg.sv | 28 ++
 rtl/light_sequencer.sv | 113 +++++++++++
 tb/tb_light_sequencer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/light_sequencer_pkg.sv
// Shared types and defaults for the traffic light sequencer.
// Durations are 7-bit counts; states cover run and set modes.
package light_sequencer_pkg;

  typedef enum logic [2:0] {
    RED,
    GREEN,
    YELLOW,
    SET_R,
    SET_Y,
    SET_G
  } state_t;

  typedef logic [6:0] dur_t;

  localparam dur_t LS_DEF_R  = 7'd10;
  localparam dur_t LS_DEF_Y  = 7'd3;
  localparam dur_t LS_DEF_G  = 7'd7;
  localparam dur_t LS_T_MAX  = 7'd99;

endpackage

// File: rtl/light_sequencer_if.sv
// Phase-end/button inputs and light/duration outputs of the sequencer.
// master drives stimulus, slave is the sequencer side.
interface light_sequencer_if;

  logic r_end;
  logic y_end;
  logic g_end;
  logic btn_mode;
  logic btn_inc;
  logic fsm_r;
  logic fsm_y;
  logic fsm_g;
  logic set_mode;
  logic c_s;
  light_sequencer_pkg::dur_t time_r;
  light_sequencer_pkg::dur_t time_y;
  light_sequencer_pkg::dur_t time_g;

  modport master (
    output r_end, y_end, g_end,
    output btn_mode, btn_inc,
    input  fsm_r, fsm_y, fsm_g,
    input  set_mode, c_s,
    input  time_r, time_y, time_g
  );

  modport slave (
    input  r_end, y_end, g_end,
    input  btn_mode, btn_inc,
    output fsm_r, fsm_y, fsm_g,
    output set_mode, c_s,
    output time_r, time_y, time_g
  );

endinterface

// File: rtl/light_sequencer_dur_reg.sv
// Programmable duration register: loads its default on reset and
// increments on request, wrapping from the maximum back to 1.
module dur_reg
  import light_sequencer_pkg::*;
#(
  parameter dur_t DEF   = LS_DEF_R,
  parameter dur_t T_MAX = LS_T_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  output dur_t q
);

  // >= also recovers a default that was set above the maximum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= DEF;
    end else if (inc) begin
      if (q >= T_MAX) begin
        q <= 7'd1;
      end else begin
        q <= q + 7'd1;
      end
    end
  end

endmodule

// File: rtl/light_sequencer.sv
// Traffic light sequencer: RED->GREEN->YELLOW on counter end pulses,
// with a set mode that edits the three phase durations.
module light_sequencer
  import light_sequencer_pkg::*;
#(
  parameter dur_t DEF_R = LS_DEF_R,
  parameter dur_t DEF_Y = LS_DEF_Y,
  parameter dur_t DEF_G = LS_DEF_G,
  parameter dur_t T_MAX = LS_T_MAX
) (
  input  logic clk,
  input  logic rst,
  light_sequencer_if.slave io
);

  state_t state;
  state_t nxt;
  logic [2:0] lit_q;
  logic set_q;
  logic cs_q;
  logic inc_r;
  logic inc_y;
  logic inc_g;
  logic bump;

  function automatic state_t next_state(
    input state_t s,
    input logic re,
    input logic ye,
    input logic ge,
    input logic bm
  );
    state_t n;
    n = s;
    unique case (s)
      RED:     n = bm ? SET_R : (re ? GREEN : RED);
      GREEN:   n = bm ? SET_R : (ge ? YELLOW : GREEN);
      YELLOW:  n = bm ? SET_R : (ye ? RED : YELLOW);
      SET_R:   n = bm ? SET_Y : SET_R;
      SET_Y:   n = bm ? SET_G : SET_Y;
      SET_G:   n = bm ? RED : SET_G;
      default: n = RED;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] lights(input state_t s);
    logic [2:0] l;
    l = 3'b100;
    unique case (s)
      RED, SET_R:    l = 3'b100;
      YELLOW, SET_Y: l = 3'b010;
      GREEN, SET_G:  l = 3'b001;
      default:       l = 3'b100;
    endcase
    return l;
  endfunction

  function automatic logic is_set(input state_t s);
    return (s == SET_R) || (s == SET_Y) || (s == SET_G);
  endfunction

  assign nxt = next_state(state, io.r_end, io.y_end,
                          io.g_end, io.btn_mode);

  // mode beats inc when both arrive together
  assign bump  = io.btn_inc & ~io.btn_mode;
  assign inc_r = bump & (state == SET_R);
  assign inc_y = bump & (state == SET_Y);
  assign inc_g = bump & (state == SET_G);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RED;
      lit_q <= 3'b100;
      set_q <= 1'b0;
      cs_q  <= 1'b0;
    end else begin
      state <= nxt;
      lit_q <= lights(nxt);
      set_q <= is_set(nxt);
      cs_q  <= (state == SET_G) & io.btn_mode;
    end
  end

  assign io.fsm_r    = lit_q[2];
  assign io.fsm_y    = lit_q[1];
  assign io.fsm_g    = lit_q[0];
  assign io.set_mode = set_q;
  assign io.c_s      = cs_q;

  dur_reg #(.DEF(DEF_R), .T_MAX(T_MAX)) u_dur_r (
    .clk (clk),
    .rst (rst),
    .inc (inc_r),
    .q   (io.time_r)
  );

  dur_reg #(.DEF(DEF_Y), .T_MAX(T_MAX)) u_dur_y (
    .clk (clk),
    .rst (rst),
    .inc (inc_y),
    .q   (io.time_y)
  );

  dur_reg #(.DEF(DEF_G), .T_MAX(T_MAX)) u_dur_g (
    .clk (clk),
    .rst (rst),
    .inc (inc_g),
    .q   (io.time_g)
  );

endmodule

// File: tb/tb_light_sequencer.sv
// Scoreboard bench for light_sequencer: a behavioural model queues
// expected outputs per driven cycle; they are popped after the edge.
module tb_light_sequencer;
  import light_sequencer_pkg::*;

  typedef struct {
    logic [2:0] lit;
    logic       sm;
    logic       cs;
    dur_t       tr;
    dur_t       ty;
    dur_t       tg;
  } exp_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;
  exp_t sb[$];

  state_t m_st;
  dur_t   m_r;
  dur_t   m_y;
  dur_t   m_g;
  logic   m_cs;

  light_sequencer_if io();

  light_sequencer dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  function automatic dur_t up(input dur_t v);
    if (v == 7'd99) return 7'd1;
    return v + 7'd1;
  endfunction

  task automatic m_reset();
    m_st = RED;
    m_r  = 7'd10;
    m_y  = 7'd3;
    m_g  = 7'd7;
    m_cs = 1'b0;
  endtask

  task automatic m_step(input logic re, ye, ge, bm, bi);
    m_cs = (m_st == SET_G) && bm;
    if (m_st == RED || m_st == GREEN || m_st == YELLOW) begin
      if (bm) m_st = SET_R;
      else if (m_st == RED && re) m_st = GREEN;
      else if (m_st == GREEN && ge) m_st = YELLOW;
      else if (m_st == YELLOW && ye) m_st = RED;
    end else if (bm) begin
      if (m_st == SET_R) m_st = SET_Y;
      else if (m_st == SET_Y) m_st = SET_G;
      else m_st = RED;
    end else if (bi) begin
      if (m_st == SET_R) m_r = up(m_r);
      else if (m_st == SET_Y) m_y = up(m_y);
      else m_g = up(m_g);
    end
  endtask

  function automatic exp_t m_exp();
    exp_t e;
    e.lit = (m_st == RED || m_st == SET_R) ? 3'b100 :
            (m_st == YELLOW || m_st == SET_Y) ? 3'b010 : 3'b001;
    e.sm  = (m_st == SET_R || m_st == SET_Y || m_st == SET_G);
    e.cs  = m_cs;
    e.tr  = m_r;
    e.ty  = m_y;
    e.tg  = m_g;
    return e;
  endfunction

  task automatic compare(input exp_t e);
    check("lights", {io.fsm_r, io.fsm_y, io.fsm_g}, e.lit);
    check("set_mode", io.set_mode, e.sm);
    check("c_s", io.c_s, e.cs);
    check("time_r", io.time_r, e.tr);
    check("time_y", io.time_y, e.ty);
    check("time_g", io.time_g, e.tg);
  endtask

  task automatic step(input logic re, ye, ge, bm, bi);
    exp_t e;
    @(negedge clk);
    io.r_end    = re;
    io.y_end    = ye;
    io.g_end    = ge;
    io.btn_mode = bm;
    io.btn_inc  = bi;
    m_step(re, ye, ge, bm, bi);
    sb.push_back(m_exp());
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compare(e);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    io.r_end = 1'b0;
    io.y_end = 1'b0;
    io.g_end = 1'b0;
    io.btn_mode = 1'b0;
    io.btn_inc = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_lights", {io.fsm_r, io.fsm_y, io.fsm_g}, 3'b100);
    check("rst_sm", io.set_mode, 1'b0);
    check("rst_cs", io.c_s, 1'b0);
    check("rst_tr", io.time_r, 7'd10);
    check("rst_ty", io.time_y, 7'd3);
    check("rst_tg", io.time_g, 7'd7);
    @(negedge clk);
    rst = 1'b0;

    // normal run, then stray/mismatched ends and inc
    step(1, 0, 0, 0, 0);
    check("to_green", {io.fsm_r, io.fsm_y, io.fsm_g}, 3'b001);
    step(0, 0, 1, 0, 0);
    check("to_yellow", {io.fsm_r, io.fsm_y, io.fsm_g}, 3'b010);
    step(0, 1, 0, 0, 0);
    check("to_red", {io.fsm_r, io.fsm_y, io.fsm_g}, 3'b100);
    step(0, 0, 1, 0, 0);
    check("stray_g", {io.fsm_r, io.fsm_y, io.fsm_g}, 3'b100);
    step(0, 1, 0, 0, 1);
    check("inc_ign", io.time_r, 7'd10);

    // edit red: +3, walk out of set mode
    step(0, 0, 0, 1, 0);
    check("set_r", io.set_mode, 1'b1);
    repeat (3) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    step(1, 1, 1, 1, 0);
    check("set_g", {io.fsm_r, io.fsm_y, io.fsm_g}, 3'b001);
    step(0, 0, 0, 1, 0);
    check("cs_hi", io.c_s, 1'b1);
    check("tr_13", io.time_r, 7'd13);
    step(0, 0, 0, 0, 0);
    check("cs_lo", io.c_s, 1'b0);

    // green wrap at the maximum
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    repeat (92) step(0, 0, 0, 0, 1);
    check("tg_99", io.time_g, 7'd99);
    step(0, 0, 0, 0, 1);
    check("tg_1", io.time_g, 7'd1);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    check("persist", io.time_g, 7'd1);

    // collision and ignored end in set mode
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    check("coll_st", {io.fsm_r, io.fsm_y, io.fsm_g}, 3'b010);
    check("coll_tr", io.time_r, 7'd13);
    step(1, 0, 0, 0, 0);
    check("re_ign", {io.fsm_r, io.fsm_y, io.fsm_g}, 3'b010);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("ty_5", io.time_y, 7'd5);

    // asynchronous reset mid-edit, no clock edge
    @(negedge clk);
    io.btn_inc = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_lit", {io.fsm_r, io.fsm_y, io.fsm_g}, 3'b100);
    check("arst_sm", io.set_mode, 1'b0);
    check("arst_ty", io.time_y, 7'd3);
    check("arst_tr", io.time_r, 7'd10);
    check("arst_tg", io.time_g, 7'd1 + 7'd6);
    m_reset();
    @(negedge clk);
    rst = 1'b0;

    // random mix against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
